mem_stage_ctrl: RTL
===================

Name: mem_stage_ctrl

Overview:
- Parametrised successor to the LC-3b pipeline MEM stage.
- Adds a real memory handshake with stall generation, byte-lane access for LDB/STB, and two-phase indirect access for LDI/STI.
- Adds a registered MEM/WB output stage and a saturating stall counter.
- Sits between EX/MEM pipeline latches and WB; drives the data-memory port.

Parameters:
- WIDTH, 16, data/address width in bits; even, >=16.
- BE_WIDTH, WIDTH/8, byte-enable width.
- CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  instruction in MEM is valid.
- req_read  in  1  load request.
- req_write  in  1  store request.
- req_byte  in  1  byte access (LDB/STB).
- req_indirect  in  1  indirect access (LDI/STI).
- req_addr  in  WIDTH  effective address from EX.
- req_wdata  in  WIDTH  store data / ALU result passthrough.
- req_dr  in  3  destination register.
- mem_rdata  in  WIDTH  memory read data.
- mem_resp  in  1  memory access complete.
- mem_address  out  WIDTH  memory address.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_wdata  out  WIDTH  memory write data.
- mem_byte_enable  out  BE_WIDTH  write lane enables.
- stall  out  1  hold upstream pipeline.
- out_valid  out  1  registered valid to WB.
- out_data  out  WIDTH  registered load data or passthrough result.
- out_dr  out  3  registered destination register.
- out_misaligned  out  1  registered: word access had addr[0]=1.
- stall_count  out  CNT_WIDTH  saturating count of stalled cycles.

Behaviour:
- Reset (async, reset_n=0): state=PH1.
  - out_valid, out_data, out_dr, out_misaligned, stall_count all 0.
  - Memory strobes 0 immediately, including mid-access; any pending mem_resp is then ignored.
- is_mem = req_valid & (req_read | req_write).
- req_read & req_write together is illegal: it is treated as a write.
- States:
  - PH1: first access.
  - PH2: second access of an indirect op; holds pointer register ptr.
- PH1 drive:
  - mem_address = req_addr with bit0 cleared for word accesses, unchanged for byte accesses.
  - If req_indirect, the PH1 access is always a word read (the pointer fetch).
  - Otherwise mem_read/mem_write follow the request.
- PH2 drive:
  - mem_address = ptr with bit0 cleared.
  - Op is a read for LDI, a write for STI.
- Strobes stay asserted and stable until the cycle mem_resp=1.
- mem_resp with no strobe asserted is ignored.
- Transitions:
  - PH1 with is_mem & req_indirect & mem_resp: ptr <= mem_rdata, go to PH2.
  - PH2 with mem_resp: go to PH1.
  - All other cases hold state.
- Final access is the PH1 access of a non-indirect op, or the PH2 access of an indirect op.
- stall = is_mem & ~(final access & mem_resp), combinational.
  - Upstream holds req_* stable while stall=1.
  - Non-memory valid instructions never stall.
- Byte store:
  - mem_wdata = low byte replicated to both lanes.
  - mem_byte_enable = 2'b01 when addr[0]=0, 2'b10 when addr[0]=1.
- Word store: mem_byte_enable all ones, mem_wdata = req_wdata.
- Byte load: out_data = selected byte (addr[0] selects the high byte), zero-extended.
- Word load: out_data = mem_rdata.
- Output register, updated at every rising edge:
  - stall=0: out_valid<=req_valid; out_data<=load data for loads, else req_wdata; out_dr<=req_dr; out_misaligned<=is_mem & ~req_byte & req_addr[0].
  - stall=1: out_valid<=0 (bubble inserted); other out_* hold.
- Latency: a non-memory op appears at out_* one cycle after entering MEM.
  - A memory op appears one cycle after its final mem_resp.
  - A zero-wait-state load (mem_resp in its first cycle) therefore has 1-cycle latency.
- stall_count increments on every cycle with stall=1 and saturates at all ones.
- If req_valid drops while in PH2 (flush), the FSM returns to PH1 and deasserts strobes.

Test Plan:
- Zero-wait word load: req_addr=0x3000, mem_rdata=0xBEEF, mem_resp same cycle -> stall never 1; next cycle out_valid=1, out_data=0xBEEF.
- Byte store with 3 wait states: req_addr=0x1001, req_wdata=0x00A5 -> mem_byte_enable=2'b10, mem_wdata=0xA5A5; stall=1 for 3 cycles; stall_count=3; a single out_valid pulse.
- LDI: req_addr=0x2000, pointer read returns 0x4002, final read returns 0x1234 -> second mem_address=0x4002; out_data=0x1234; stall deasserts only on the second mem_resp.
- Byte load at 0x0101, mem_rdata=0xC37F -> out_data=0x00C3.
- Misaligned word store at 0x0103 -> mem_address=0x0102, byte_enable all ones; out_misaligned=1 for one cycle.
- Reset asserted in PH2 with mem_read high -> mem_read=0 immediately; out_valid=0, stall_count=0; after release, a new load completes normally. Saturation: CNT_WIDTH=4 with 20 stall cycles -> stall_count=15.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM stage controller: memory handshake with stall generation, byte lanes,
// two-phase indirect access, registered MEM/WB outputs and a saturating stall counter.
module mem_stage_ctrl #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned BE_WIDTH  = WIDTH / 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  input  logic                 req_read,
  input  logic                 req_write,
  input  logic                 req_byte,
  input  logic                 req_indirect,
  input  logic [WIDTH-1:0]     req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  input  logic [2:0]           req_dr,
  input  logic [WIDTH-1:0]     mem_rdata,
  input  logic                 mem_resp,
  output logic [WIDTH-1:0]     mem_address,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic [BE_WIDTH-1:0]  mem_byte_enable,
  output logic                 stall,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [2:0]           out_dr,
  output logic                 out_misaligned,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam logic [0:0] PH1 = 1'b0;
  localparam logic [0:0] PH2 = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [WIDTH-2:0]     ptr_q, ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [2:0]           out_dr_q, out_dr_d;
  logic                 out_misaligned_q, out_misaligned_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  logic                 is_mem_c;
  logic                 is_store_c;
  logic                 final_c;
  logic                 rd_c, wr_c;
  logic [WIDTH-1:0]     addr_c;
  logic [WIDTH-1:0]     wdata_c;
  logic [BE_WIDTH-1:0]  be_c;
  logic [WIDTH-1:0]     byte_rep_c;
  logic [7:0]           byte_sel_c;
  logic [WIDTH-1:0]     load_data_c;
  logic                 stall_c;

  // Read+write together is treated as a store.
  assign is_mem_c   = req_valid & (req_read | req_write);
  assign is_store_c = req_write;

  // Replicate the store byte onto every lane; high byte selected by addr[0] on loads.
  always_comb begin
    byte_rep_c = '0;
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      byte_rep_c[i*8 +: 8] = req_wdata[7:0];
    end
    byte_sel_c  = req_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    load_data_c = (req_byte & ~req_indirect) ? WIDTH'(byte_sel_c) : mem_rdata;
  end

  // Next-state and memory-port drive.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_c  = {req_addr[WIDTH-1:1], 1'b0};
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    wdata_c = req_wdata;
    be_c    = '1;
    final_c = 1'b0;
    case (state_q)
      PH1: begin
        if (is_mem_c) begin
          if (req_indirect) begin
            rd_c = 1'b1;
            if (mem_resp) begin
              state_d = PH2;
              ptr_d   = mem_rdata[WIDTH-1:1];
            end
          end else begin
            final_c = 1'b1;
            rd_c    = ~is_store_c;
            wr_c    = is_store_c;
            if (req_byte) begin
              addr_c  = req_addr;
              wdata_c = byte_rep_c;
              be_c    = req_addr[0] ? BE_WIDTH'(2) : BE_WIDTH'(1);
            end
          end
        end
      end
      default: begin
        if (!is_mem_c) begin
          state_d = PH1;
        end else begin
          addr_c  = {ptr_q, 1'b0};
          rd_c    = ~is_store_c;
          wr_c    = is_store_c;
          final_c = 1'b1;
          if (mem_resp) state_d = PH1;
        end
      end
    endcase
  end

  assign stall_c = is_mem_c & ~(final_c & mem_resp);

  // Output stage: bubble while stalled, otherwise capture the retiring instruction.
  always_comb begin
    out_valid_d      = 1'b0;
    out_data_d       = out_data_q;
    out_dr_d         = out_dr_q;
    out_misaligned_d = out_misaligned_q;
    stall_count_d    = stall_count_q;
    if (!stall_c) begin
      out_valid_d      = req_valid;
      out_data_d       = (is_mem_c & ~is_store_c) ? load_data_c : req_wdata;
      out_dr_d         = req_dr;
      out_misaligned_d = is_mem_c & ~req_byte & req_addr[0];
    end else if (stall_count_q != {CNT_WIDTH{1'b1}}) begin
      stall_count_d = stall_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= PH1;
      ptr_q            <= '0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_dr_q         <= '0;
      out_misaligned_q <= 1'b0;
      stall_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
      out_dr_q         <= out_dr_d;
      out_misaligned_q <= out_misaligned_d;
      stall_count_q    <= stall_count_d;
    end
  end

  // Strobes drop the moment reset asserts, even mid-access.
  assign mem_address     = addr_c;
  assign mem_read        = rd_c & reset_n;
  assign mem_write       = wr_c & reset_n;
  assign mem_wdata       = wdata_c;
  assign mem_byte_enable = be_c;
  assign stall           = stall_c;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign out_dr          = out_dr_q;
  assign out_misaligned  = out_misaligned_q;
  assign stall_count     = stall_count_q;

endmodule
